// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Multi-cycle radix-2 restoring divider (DIV/DIVU) for the E stage.
// Revision : 1.0
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 startE,
    input  logic                 signedE,
    input  logic                 annulE,
    input  logic [WIDTH-1:0]     opaE,
    input  logic [WIDTH-1:0]     opbE,
    output logic [2*WIDTH-1:0]   resultE,
    output logic                 readyE,
    output logic                 stall_divE
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY    = 2'd1;
    localparam logic [1:0] c_DIVZERO = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [2*WIDTH-1:0] r_result;

    logic               w_start;
    logic               w_last;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH-1:0]   w_sub;
    logic               w_ge;
    logic [WIDTH-1:0]   w_new_rem;
    logic [WIDTH-1:0]   w_new_quo;
    logic [WIDTH-1:0]   w_fix_rem;
    logic [WIDTH-1:0]   w_fix_quo;

    assign w_start = startE & ~annulE;
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_abs_a = (signedE & opaE[WIDTH-1]) ? (~opaE + 1'b1) : opaE;
    assign w_abs_b = (signedE & opbE[WIDTH-1]) ? (~opbE + 1'b1) : opbE;

    // Remainder gains one extra bit after the shift, since |divisor| may use all WIDTH bits.
    assign w_shifted = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_shifted >= {1'b0, r_div});
    assign w_sub     = w_shifted[WIDTH-1:0] - r_div;
    assign w_new_rem = w_ge ? w_sub : w_shifted[WIDTH-1:0];
    assign w_new_quo = {r_quo[WIDTH-2:0], w_ge};
    assign w_fix_rem = r_sign_r ? (~w_new_rem + 1'b1) : w_new_rem;
    assign w_fix_quo = r_sign_q ? (~w_new_quo + 1'b1) : w_new_quo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_next = (opbE == '0) ? c_DIVZERO : c_BUSY;
                end
            end
            c_BUSY: begin
                if (annulE) begin
                    w_next = c_IDLE;
                end else if (w_last) begin
                    w_next = c_DONE;
                end
            end
            c_DIVZERO: w_next = annulE ? c_IDLE : c_DONE;
            c_DONE:    w_next = c_IDLE;
            default:   w_next = c_IDLE;
        endcase
    end

    always_comb begin
        readyE     = (r_state == c_DONE) & ~annulE;
        stall_divE = startE & ~readyE & ~annulE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_quo    <= w_abs_a;
                        r_div    <= w_abs_b;
                        r_sign_q <= signedE & (opaE[WIDTH-1] ^ opbE[WIDTH-1]);
                        r_sign_r <= signedE & opaE[WIDTH-1];
                    end
                end
                c_BUSY: begin
                    if (!annulE) begin
                        r_rem <= w_new_rem;
                        r_quo <= w_new_quo;
                        r_cnt <= r_cnt + 1'b1;
                        // Final iteration: publish the sign-corrected result as DONE is entered.
                        if (w_last) begin
                            r_result <= {w_fix_rem, w_fix_quo};
                        end
                    end
                end
                c_DIVZERO: begin
                    if (!annulE) begin
                        r_result <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resultE = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Scoreboard testbench for div_unit (latency, signs, annul, resets).
// Revision : 1.0
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        startE;
    logic        signedE;
    logic        annulE;
    logic [31:0] opaE;
    logic [31:0] opbE;
    logic [63:0] resultE;
    logic        readyE;
    logic        stall_divE;

    int          n_tests;
    int          n_fail;
    logic [63:0] sb_q[$];
    logic [63:0] last_res;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .startE     (startE),
        .signedE    (signedE),
        .annulE     (annulE),
        .opaE       (opaE),
        .opbE       (opbE),
        .resultE    (resultE),
        .readyE     (readyE),
        .stall_divE (stall_divE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called just after a rising edge; returns just after the edge that leaves DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int exp_lat,
                          input logic keep, input logic toggle, input string name);
        int          cyc;
        int          stalls;
        logic        done;
        logic [63:0] want;
        sb_q.push_back(exp);
        opaE    = a;
        opbE    = b;
        signedE = s;
        annulE  = 1'b0;
        startE  = 1'b1;
        cyc     = 0;
        stalls  = 0;
        done    = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (readyE) begin
                done = 1'b1;
                want = sb_q.pop_front();
                last_res = want;
                n_tests++;
                if (resultE !== want) begin
                    n_fail++;
                    $display("FAIL %s result: got %h expected %h", name, resultE, want);
                end
                n_tests++;
                if (cyc !== exp_lat) begin
                    n_fail++;
                    $display("FAIL %s ready_cycle: got %0d expected %0d", name, cyc, exp_lat);
                end
                n_tests++;
                if (stalls !== exp_lat) begin
                    n_fail++;
                    $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_lat);
                end
            end else if (stall_divE) begin
                stalls++;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                cyc++;
                if (toggle && cyc == 5) begin
                    opaE    = $urandom;
                    opbE    = $urandom;
                    signedE = ~signedE;
                end
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: got no readyE expected readyE by cycle %0d", name, exp_lat);
            void'(sb_q.pop_front());
        end
        if (!keep) startE = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        startE  = 1'b0;
        signedE = 1'b0;
        annulE  = 1'b0;
        opaE    = 32'd0;
        opbE    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (readyE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", readyE);
        end
        n_tests++;
        if (stall_divE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b expected 0", stall_divE);
        end
        n_tests++;
        if (resultE !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 0", resultE);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_divu_basic();
        run_op(32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 1'b0, 1'b0, "divu_100_7");
        @(negedge clk);
        n_tests++;
        if (readyE !== 1'b0 || stall_divE !== 1'b0) begin
            n_fail++;
            $display("FAIL divu_after_idle: got ready=%b stall=%b expected 0/0", readyE, stall_divE);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_divzero();
        run_op(32'd5, 32'd0, 1'b0, 64'd0, 2, 1'b0, 1'b0, "divu_5_0");
        run_op(32'hFFFF_FFF0, 32'd0, 1'b1, 64'd0, 2, 1'b0, 1'b0, "div_neg_0");
    endtask

    task automatic test_signed();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0, 1'b0, "div_m7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 1'b0, 1'b0, "div_7_m2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33, 1'b0, 1'b0, "div_min_m1");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, {32'h1, 32'h7FFF_FFFC}, 33, 1'b0, 1'b0, "divu_big_2");
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            if (b == 32'd0) b = 32'd3;
            s = i[0];
            run_op(a, b, s, model(a, b, s), 33, 1'b0, 1'b0, "rand_div");
        end
    endtask

    task automatic test_annul();
        int n_ready;
        run_op(32'd1000, 32'd7, 1'b0, {32'd6, 32'd142}, 33, 1'b0, 1'b0, "divu_1000_7");
        opaE    = 32'd1000;
        opbE    = 32'd3;
        signedE = 1'b0;
        startE  = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        annulE = 1'b1;
        @(negedge clk);
        n_tests++;
        if (stall_divE !== 1'b0 || readyE !== 1'b0) begin
            n_fail++;
            $display("FAIL annul_stall: got stall=%b ready=%b expected 0/0", stall_divE, readyE);
        end
        @(posedge clk);
        #1;
        annulE  = 1'b0;
        startE  = 1'b0;
        n_ready = 0;
        repeat (40) begin
            @(negedge clk);
            if (readyE) n_ready++;
        end
        n_tests++;
        if (n_ready !== 0) begin
            n_fail++;
            $display("FAIL annul_no_ready: got %0d ready cycles expected 0", n_ready);
        end
        n_tests++;
        if (resultE !== last_res) begin
            n_fail++;
            $display("FAIL annul_result_kept: got %h expected %h", resultE, last_res);
        end
        @(posedge clk);
        #1;
        run_op(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 33, 1'b0, 1'b0, "after_annul");
    endtask

    task automatic test_back_to_back();
        run_op(32'd50, 32'd6, 1'b0, {32'd2, 32'd8}, 33, 1'b1, 1'b0, "b2b_first");
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 33, 1'b0, 1'b1, "b2b_second");
    endtask

    task automatic test_async_reset();
        opaE    = 32'd12345;
        opbE    = 32'd67;
        signedE = 1'b0;
        startE  = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_tests++;
        if (readyE !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_ready: got %b expected 0", readyE);
        end
        n_tests++;
        if (resultE !== 64'd0) begin
            n_fail++;
            $display("FAIL arst_result: got %h expected 0", resultE);
        end
        startE = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if (readyE !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_idle: got ready=%b expected 0", readyE);
        end
        @(posedge clk);
        #1;
        run_op(32'd12345, 32'd67, 1'b0, {32'd17, 32'd184}, 33, 1'b0, 1'b0, "after_arst");
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        last_res = 64'd0;
        test_reset();
        test_divu_basic();
        test_divzero();
        test_signed();
        test_annul();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
